itl_wr_ctrl: RTL and testbench
==============================

ITL_WR_CTRL -- requirements
Module: itl_wr_ctrl

Interface
REQ-001 Parameters SHALL be: D_WIDTH, 2, symbol width; A_WIDTH, 12, RAM address width.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 n_rst  in  1  reset, synchronous and active-high (port name kept per codebase).
REQ-004 start  in  1  one-cycle request to begin a PB interleave.
REQ-005 pb_size  in  2  PB select sampled with start: 0=PB16, 1=PB136, 2=PB520, 3=reserved.
REQ-006 s_data  in  D_WIDTH  input symbol (bit pair).
REQ-007 s_vld  in  1  s_data valid.
REQ-008 s_rdy  out  1  block accepts s_data; beat transfers when s_vld&&s_rdy.
REQ-009 waddr  out  A_WIDTH  local RAM address to interleaver RAM.
REQ-010 wdata  out  D_WIDTH  write data to interleaver RAM.
REQ-011 wen  out  1  RAM write enable.
REQ-012 pb_offset  out  A_WIDTH  ROM region offset for selected PB.
REQ-013 din_vld  out  1  read-sweep valid to interleaver RAM.
REQ-014 busy  out  1  high from accepted start until done.
REQ-015 done  out  1  one-cycle pulse at end of PB.
REQ-016 err  out  1  one-cycle pulse on start with pb_size=3.

Function
REQ-017 PB length L (symbols) SHALL be 64/544/2080 and pb_offset 0/64/608 for PB16/PB136/PB520.
REQ-018 FSM states SHALL be IDLE, WRITE, GAP, READ, FLUSH.
REQ-019 IDLE: s_rdy=0, wen=0, din_vld=0; start with pb_size<3 latches L and pb_offset, clears counter, -> WRITE, busy=1 next cycle.
REQ-020 IDLE: start with pb_size=3 SHALL pulse err next cycle and remain IDLE.
REQ-021 start while busy SHALL be ignored (no err, no relatch).
REQ-022 WRITE: s_rdy=1; each accepted beat at cycle t SHALL drive wen=1, waddr=cnt, wdata=s_data at t+1; cnt increments per beat.
REQ-023 WRITE: cycles without accepted beat SHALL drive wen=0; waddr/wdata hold.
REQ-024 Beat accepted with cnt=L-1 SHALL clear cnt, drop s_rdy next cycle, -> GAP.
REQ-025 GAP: one cycle, wen=0, din_vld=0, guaranteeing last write committed before reads; -> READ.
REQ-026 READ: wen=0, din_vld=1, waddr=cnt, cnt increments every cycle (no backpressure); after waddr=L-1 issued -> FLUSH.
REQ-027 FLUSH: din_vld=0 for 2 cycles (downstream dout_vld latency), then done=1 one cycle, busy=0 same cycle, -> IDLE.
REQ-028 pb_offset SHALL hold constant from latch until next accepted start.
REQ-029 Counter SHALL be A_WIDTH bits, never exceed L-1; no wrap beyond L.
REQ-030 Total latency start-to-done with no input stalls SHALL be L(write)+1(GAP)+L(read)+2(FLUSH)+1 cycles.

Reset
REQ-031 n_rst=1 SHALL force IDLE, cnt=0, and all outputs (s_rdy, waddr, wdata, wen, pb_offset, din_vld, busy, done, err) to 0 next edge.
REQ-032 Reset mid-PB SHALL abandon the PB; no done pulse; next start begins fresh.

Structure
REQ-033 Shared package itl_pkg SHALL hold PB length constants, PB offset constants, pb_size encoding and FSM state enum.
REQ-034 No sub-module; block instantiated beside the interleaver RAM in the PB top level.

Verification
REQ-035 Reset then start, pb_size=0, 64 beats back-to-back -> wen high 64 cycles, waddr 0..63, 1 GAP cycle, din_vld 64 cycles waddr 0..63, done at cycle 132 after start.
REQ-036 pb_size=2, s_vld toggling 50% -> exactly 2080 writes, waddr contiguous 0..2079, pb_offset=608 throughout, no write during GAP/READ.
REQ-037 start with pb_size=3 -> err one cycle, busy stays 0, no wen.
REQ-038 start pulsed during READ of PB136 -> ignored, pb_offset stays 64, single done.
REQ-039 n_rst asserted at write beat 300 of PB136 -> all outputs 0 next cycle, no done; fresh PB16 afterwards completes normally.
REQ-040 PB136 read sweep -> last waddr=543 with din_vld=1, then 2 idle cycles, done pulse.

Source files
------------

// File: rtl/itl_pkg.sv
// Shared PB geometry and FSM encoding for the interleaver write/read controller.
// Combinational helpers only; no latency or flow control of its own.
package itl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    PB16    = 2'd0,
    PB136   = 2'd1,
    PB520   = 2'd2,
    PB_RSVD = 2'd3
  } pb_size_t;

  localparam int unsigned PB16_LEN  = 64;
  localparam int unsigned PB136_LEN = 544;
  localparam int unsigned PB520_LEN = 2080;

  localparam int unsigned PB16_OFF  = 0;
  localparam int unsigned PB136_OFF = 64;
  localparam int unsigned PB520_OFF = 608;

  // Idle cycles after the read sweep that cover the RAM's output latency.
  localparam int unsigned FLUSH_CYCLES = 2;

  function automatic int unsigned pb_len(input logic [1:0] sel);
    case (sel)
      PB16:    return PB16_LEN;
      PB136:   return PB136_LEN;
      PB520:   return PB520_LEN;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned pb_off(input logic [1:0] sel);
    case (sel)
      PB16:    return PB16_OFF;
      PB136:   return PB136_OFF;
      PB520:   return PB520_OFF;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/itl_wr_ctrl.sv
// Fills the interleaver RAM with one PB of symbols, then sweeps it for readout; all outputs registered.
// Start-to-done is 2L+4 cycles without stalls; s_vld stalls only extend the write phase, reads never stall.
module itl_wr_ctrl
  import itl_pkg::*;
#(
  parameter int D_WIDTH = 2,
  parameter int A_WIDTH = 12
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [1:0]         pb_size,
  input  logic [D_WIDTH-1:0] s_data,
  input  logic               s_vld,
  output logic               s_rdy,
  output logic [A_WIDTH-1:0] waddr,
  output logic [D_WIDTH-1:0] wdata,
  output logic               wen,
  output logic [A_WIDTH-1:0] pb_offset,
  output logic               din_vld,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic [A_WIDTH-1:0] len_q, len_d;
  logic [A_WIDTH-1:0] off_q, off_d;
  logic [A_WIDTH-1:0] waddr_q, waddr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic s_rdy_q, s_rdy_d;
  logic wen_q, wen_d;
  logic din_vld_q, din_vld_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic beat;
  logic cnt_last;

  assign beat     = s_vld && s_rdy_q;
  assign cnt_last = (cnt_q == len_q - A_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    off_d     = off_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    s_rdy_d   = s_rdy_q;
    wen_d     = 1'b0;
    din_vld_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (pb_size == PB_RSVD) begin
            err_d = 1'b1;
          end else begin
            len_d   = A_WIDTH'(pb_len(pb_size));
            off_d   = A_WIDTH'(pb_off(pb_size));
            cnt_d   = '0;
            s_rdy_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (beat) begin
          wen_d   = 1'b1;
          waddr_d = cnt_q;
          wdata_d = s_data;
          if (cnt_last) begin
            cnt_d   = '0;
            s_rdy_d = 1'b0;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q + A_WIDTH'(1);
          end
        end
      end
      // The final write is on the RAM port during this cycle; reads start after it.
      ST_GAP: state_d = ST_READ;
      ST_READ: begin
        din_vld_d = 1'b1;
        waddr_d   = cnt_q;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + A_WIDTH'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == A_WIDTH'(FLUSH_CYCLES)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + A_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      off_q     <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      s_rdy_q   <= 1'b0;
      wen_q     <= 1'b0;
      din_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      off_q     <= off_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      s_rdy_q   <= s_rdy_d;
      wen_q     <= wen_d;
      din_vld_q <= din_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_rdy     = s_rdy_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wen       = wen_q;
  assign pb_offset = off_q;
  assign din_vld   = din_vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_itl_wr_ctrl.sv
// Bench for itl_wr_ctrl: a phase-arithmetic reference model checked every cycle,
// plus hand-computed expectations per directed scenario.
module tb_itl_wr_ctrl;
  localparam int DW = 2;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic n_rst, start, s_vld;
  logic [1:0] pb_size;
  logic [DW-1:0] s_data;
  logic s_rdy, wen, din_vld, busy, done, err;
  logic [AW-1:0] waddr, pb_offset;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  itl_wr_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .pb_size(pb_size),
    .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy), .waddr(waddr),
    .wdata(wdata), .wen(wen), .pb_offset(pb_offset), .din_vld(din_vld),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: PB geometry tables and a per-PB phase position.
  int len_tab [3] = '{64, 544, 2080};
  int off_tab [3] = '{0, 64, 608};
  bit m_active = 1'b0;
  int m_len, m_beats, m_post;
  int cyc = 0;
  int start_cyc = 0;
  logic exp_srdy, exp_wen, exp_din, exp_busy, exp_done, exp_err;
  logic [AW-1:0] exp_waddr, exp_off;
  logic [DW-1:0] exp_wdata;

  always @(posedge clk) begin
    cyc++;
    exp_wen  = 1'b0;
    exp_din  = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n_rst) begin
      m_active  = 1'b0;
      exp_srdy  = 1'b0;
      exp_waddr = '0;
      exp_wdata = '0;
      exp_off   = '0;
      exp_busy  = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        if (pb_size == 2'd3) begin
          exp_err = 1'b1;
        end else begin
          m_active  = 1'b1;
          m_len     = len_tab[pb_size];
          exp_off   = AW'(off_tab[pb_size]);
          m_beats   = 0;
          m_post    = -1;
          exp_busy  = 1'b1;
          exp_srdy  = 1'b1;
          start_cyc = cyc;
        end
      end
    end else if (m_beats < m_len) begin
      if (s_vld && exp_srdy) begin
        exp_wen   = 1'b1;
        exp_waddr = AW'(m_beats);
        exp_wdata = s_data;
        m_beats++;
        if (m_beats == m_len) begin
          exp_srdy = 1'b0;
          m_post   = 0;
        end
      end
    end else begin
      // post 1: gap, 2..L+1: read sweep, L+2..L+3: flush, L+4: done
      m_post++;
      if (m_post >= 2 && m_post <= m_len + 1) begin
        exp_din   = 1'b1;
        exp_waddr = AW'(m_post - 2);
      end
      if (m_post == m_len + 4) begin
        exp_done = 1'b1;
        exp_busy = 1'b0;
        m_active = 1'b0;
      end
    end
  end

  // Observation statistics used by the scenario checks.
  int wr_cnt = 0, last_wr = 0, last_wr_cyc = 0;
  int din_cnt = 0, last_din = 0, last_din_cyc = 0, din_start_cyc = 0;
  int done_cnt = 0, done_cyc = 0, err_cnt = 0, busy_cnt = 0, off_bad = 0;
  logic prev_din = 1'b0;
  logic [AW-1:0] want_off = '0;

  always @(posedge clk) begin
    #1;
    chk("s_rdy", s_rdy, exp_srdy);
    chk("wen", wen, exp_wen);
    chk("waddr", waddr, exp_waddr);
    chk("wdata", wdata, exp_wdata);
    chk("pb_offset", pb_offset, exp_off);
    chk("din_vld", din_vld, exp_din);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("err", err, exp_err);
    if (wen === 1'b1) begin wr_cnt++; last_wr = int'(waddr); last_wr_cyc = cyc; end
    if (din_vld === 1'b1) begin
      if (prev_din !== 1'b1) din_start_cyc = cyc;
      din_cnt++; last_din = int'(waddr); last_din_cyc = cyc;
    end
    prev_din = din_vld;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (err === 1'b1) err_cnt++;
    if (busy === 1'b1) begin
      busy_cnt++;
      if (pb_offset !== want_off) off_bad++;
    end
  end

  // Symbol source: 0 = always valid, 1 = toggling, 2 = silent.
  int vld_mode = 0;
  initial begin
    s_vld  = 1'b0;
    s_data = '0;
    forever begin
      @(negedge clk);
      s_data = DW'($urandom);
      case (vld_mode)
        0:       s_vld = 1'b1;
        1:       s_vld = ~s_vld;
        default: s_vld = 1'b0;
      endcase
    end
  end

  task automatic pulse_start(input logic [1:0] sz);
    @(negedge clk);
    pb_size = sz;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, (done_cnt != d0), 1);
  endtask

  int w0, r0, d0, e0, b0, ob0, n;

  initial begin
    n_rst   = 1'b1;
    start   = 1'b0;
    pb_size = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", {s_rdy, waddr, wdata, wen, pb_offset, din_vld, busy, done, err}, 0);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);

    // PB16, back-to-back beats
    vld_mode = 0; want_off = 12'd0;
    w0 = wr_cnt; r0 = din_cnt; ob0 = off_bad;
    pulse_start(2'd0);
    wait_done(400, "pb16");
    chk("pb16_writes", wr_cnt - w0, 64);
    chk("pb16_last_wr", last_wr, 63);
    chk("pb16_wr_end_cyc", last_wr_cyc - start_cyc, 64);
    chk("pb16_gap", din_start_cyc - last_wr_cyc, 2);
    chk("pb16_reads", din_cnt - r0, 64);
    chk("pb16_last_rd", last_din, 63);
    chk("pb16_latency", done_cyc - start_cyc, 132);
    chk("pb16_offset", off_bad - ob0, 0);

    // PB520, half-rate input
    repeat (3) @(negedge clk);
    vld_mode = 1; want_off = 12'd608;
    w0 = wr_cnt; r0 = din_cnt; ob0 = off_bad;
    pulse_start(2'd2);
    wait_done(10000, "pb520");
    chk("pb520_writes", wr_cnt - w0, 2080);
    chk("pb520_last_wr", last_wr, 2079);
    chk("pb520_reads", din_cnt - r0, 2080);
    chk("pb520_offset", off_bad - ob0, 0);

    // Reserved size
    vld_mode = 0;
    repeat (3) @(negedge clk);
    w0 = wr_cnt; e0 = err_cnt; b0 = busy_cnt;
    pulse_start(2'd3);
    repeat (5) @(negedge clk);
    chk("rsvd_err", err_cnt - e0, 1);
    chk("rsvd_busy", busy_cnt - b0, 0);
    chk("rsvd_wen", wr_cnt - w0, 0);

    // PB136 with a stray start during the read sweep
    want_off = 12'd64;
    r0 = din_cnt; d0 = done_cnt; ob0 = off_bad;
    pulse_start(2'd1);
    n = 0;
    while (din_vld !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("pb136_read_seen", din_vld, 1);
    pulse_start(2'd2);
    wait_done(2000, "pb136");
    repeat (10) @(negedge clk);
    chk("pb136_single_done", done_cnt - d0, 1);
    chk("pb136_offset", off_bad - ob0, 0);
    chk("pb136_reads", din_cnt - r0, 544);
    chk("pb136_last_rd", last_din, 543);
    chk("pb136_flush", done_cyc - last_din_cyc, 3);

    // Reset in the middle of a PB136 write phase
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start(2'd1);
    n = 0;
    while (wr_cnt - w0 < 300 && n < 1000) begin @(negedge clk); n++; end
    chk("mid_beats", wr_cnt - w0, 300);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_outs", {s_rdy, waddr, wdata, wen, pb_offset, din_vld, busy, done, err}, 0);
    @(negedge clk);
    n_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);

    // Fresh PB16 afterwards
    want_off = 12'd0;
    w0 = wr_cnt; ob0 = off_bad;
    pulse_start(2'd0);
    wait_done(400, "fresh16");
    chk("fresh16_writes", wr_cnt - w0, 64);
    chk("fresh16_latency", done_cyc - start_cyc, 132);
    chk("fresh16_offset", off_bad - ob0, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
